// File: rtl/mem_io_pkg.sv
// Shared types and constants for the SLC3 memory/IO bridge: FSM states,
// the inactive strobe level and the active-low seven-segment table (gfedcba).
package mem_io_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    IO     = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic STROBE_OFF = 1'b1;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/mem_io_bridge_if.sv
// CPU-side request/completion bus of the memory/IO bridge.
interface mem_io_bridge_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  // Handshake: cpu_req is a one-cycle pulse sampled only while cpu_busy=0
  // (it is dropped otherwise, never queued); cpu_we/addr/wdata/be are sampled
  // with it. cpu_ack pulses for one cycle on completion, cpu_rdata is valid
  // then and held until the next read completes.
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [BE_W-1:0]   cpu_be;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_rdata, cpu_ack, cpu_busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_rdata, cpu_ack, cpu_busy
  );

endinterface

// File: rtl/hex_seg_decode.sv
// Registered hex-nibble to active-low seven-segment decoder; only exists in
// builds with MEM_IO_BRIDGE_SEG_EN defined.
`ifdef MEM_IO_BRIDGE_SEG_EN
module hex_seg_decode
  import mem_io_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) seg <= 7'h7F;
    else       seg <= SEG_LUT[nibble];
  end

endmodule
`endif

// File: rtl/mem_io_bridge.sv
// CPU to SRAM / memory-mapped IO bridge with wait states and byte-lane writes.
// Define MEM_IO_BRIDGE_SEG_EN to add the registered seven-segment SEG output.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int                ADDR_W      = 20,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] IO_ADDR     = 20'hFFFF,
  parameter int                NUM_HEX     = DATA_W / 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  mem_io_bridge_if.slave         cpu,
  output logic                   CE,
  output logic                   OE,
  output logic                   WE,
  output logic                   UB,
  output logic                   LB,
  output logic [ADDR_W-1:0]      A,
  input  logic [DATA_W-1:0]      Data_in,
  output logic [DATA_W-1:0]      Data_out,
  output logic                   Data_oe,
  input  logic [DATA_W-1:0]      Switches,
  output logic [4*NUM_HEX-1:0]   HEX,
`ifdef MEM_IO_BRIDGE_SEG_EN
  output logic [7*NUM_HEX-1:0]   SEG,
`endif
  output state_t                 state_dbg
);

  localparam int BE_W = DATA_W / 8;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] sw_s1, sw_s2, hex_q;
  logic              accept, sel_we, in_acc;
  logic [BE_W-1:0]   sel_be;
  logic              ce_d, oe_d, we_d, ub_d, lb_d, doe_d;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu.cpu_req) begin
          accept = 1'b1;
          if (cpu.cpu_addr == IO_ADDR) begin
            state_nxt = IO;
          end else begin
            state_nxt = ACCESS;
            cnt_nxt   = 4'(WAIT_STATES);
          end
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      IO:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Strobes are registered from the next state, so the request fields must
    // come straight from the bus on the accepting edge.
    sel_we = accept ? cpu.cpu_we : we_q;
    sel_be = accept ? cpu.cpu_be : be_q;
    in_acc = (state_nxt == ACCESS);
    ce_d   = in_acc ? 1'b0 : STROBE_OFF;
    oe_d   = (in_acc && !sel_we) ? 1'b0 : STROBE_OFF;
    we_d   = (in_acc &&  sel_we) ? 1'b0 : STROBE_OFF;
    lb_d   = !in_acc ? STROBE_OFF : (sel_we ? ~sel_be[0]      : 1'b0);
    ub_d   = !in_acc ? STROBE_OFF : (sel_we ? ~sel_be[BE_W-1] : 1'b0);
    doe_d  = in_acc && sel_we;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      we_q        <= 1'b0;
      be_q        <= '0;
      A           <= '0;
      Data_out    <= '0;
      CE          <= STROBE_OFF;
      OE          <= STROBE_OFF;
      WE          <= STROBE_OFF;
      UB          <= STROBE_OFF;
      LB          <= STROBE_OFF;
      Data_oe     <= 1'b0;
      cpu.cpu_ack <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      CE          <= ce_d;
      OE          <= oe_d;
      WE          <= we_d;
      UB          <= ub_d;
      LB          <= lb_d;
      Data_oe     <= doe_d;
      cpu.cpu_ack <= (state_nxt == DONE);
      if (accept) begin
        we_q     <= cpu.cpu_we;
        be_q     <= cpu.cpu_be;
        A        <= cpu.cpu_addr;
        Data_out <= cpu.cpu_wdata;
      end
    end
  end

  // Completion side: read data, hex register and the switch synchroniser.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cpu.cpu_rdata <= '0;
      hex_q         <= '0;
      sw_s1         <= '0;
      sw_s2         <= '0;
    end else begin
      sw_s1 <= Switches;
      sw_s2 <= sw_s1;
      if (state == ACCESS && cnt == 4'd0 && !we_q) begin
        cpu.cpu_rdata <= Data_in;
      end else if (state == IO) begin
        if (!we_q) begin
          cpu.cpu_rdata <= sw_s2;
        end else begin
          for (int b = 0; b < BE_W; b++) begin
            if (be_q[b]) hex_q[8*b +: 8] <= Data_out[8*b +: 8];
          end
        end
      end
    end
  end

  assign cpu.cpu_busy = (state != IDLE);
  assign HEX          = hex_q[4*NUM_HEX-1:0];
  assign state_dbg    = state;

`ifdef MEM_IO_BRIDGE_SEG_EN
  for (genvar g = 0; g < NUM_HEX; g++) begin : g_seg
    hex_seg_decode u_dec (
      .Clk    (Clk),
      .Reset  (Reset),
      .nibble (hex_q[4*g +: 4]),
      .seg    (SEG[7*g +: 7])
    );
  end
`endif

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: transaction-level model checked every
// cycle, plus literal expectations for latencies, data and strobe counts.
module tb_mem_io_bridge;
  import mem_io_pkg::*;

  localparam int          WS   = 1;
  localparam logic [19:0] IO_A = 20'hFFFF;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  mem_io_bridge_if #(.ADDR_W(20), .DATA_W(16)) bus ();
  logic        CE, OE, WE, UB, LB, Data_oe;
  logic [19:0] A;
  logic [15:0] Data_in, Data_out, Switches, HEX;
  state_t      state_dbg;
`ifdef MEM_IO_BRIDGE_SEG_EN
  logic [27:0] SEG;
`endif

  mem_io_bridge #(.WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset(Reset), .cpu(bus),
    .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB), .A(A),
    .Data_in(Data_in), .Data_out(Data_out), .Data_oe(Data_oe),
    .Switches(Switches), .HEX(HEX),
`ifdef MEM_IO_BRIDGE_SEG_EN
    .SEG(SEG),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- SRAM environment ----------------
  logic [15:0] sram [256];
  always @(posedge Clk) begin
    if (!CE && !WE) begin
      if (!LB) sram[A[7:0]][7:0]  <= Data_out[7:0];
      if (!UB) sram[A[7:0]][15:8] <= Data_out[15:8];
    end
  end
  assign Data_in = (!CE && !OE) ? sram[A[7:0]] : 16'hDEAD;

  // ---------------- model ----------------
  logic [15:0] m_mem [256];
  logic [15:0] m_hex = '0, m_rdata = '0, m_sw = '0;
  logic        t_have = 1'b0, t_we = 1'b0, t_io = 1'b0;
  logic [19:0] t_addr = '0, prev_addr = '0;
  logic [15:0] t_wdata = '0;
  logic [1:0]  t_be = '0;
  int          t_k = 0, t_ack = 0;

  int checks = 0, errors = 0;
  int ack_cnt = 0, ce_low = 0, oe_low = 0, we_low = 0;
  int req_cyc = 0, last_ack_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic        busy_e, ack_e, win_e;
  logic [19:0] a_e;
  always @(negedge Clk) begin
    if (!Reset) begin
      busy_e = t_have && cyc >= t_k && cyc <= t_ack;
      ack_e  = t_have && cyc == t_ack;
      win_e  = t_have && !t_io && cyc >= t_k && cyc <= t_k + WS;
      a_e    = (t_have && cyc >= t_k) ? t_addr : prev_addr;
      if (ack_e) begin
        if (t_we) begin
          for (int b = 0; b < 2; b++) begin
            if (t_be[b]) begin
              if (t_io) m_hex[8*b +: 8] = t_wdata[8*b +: 8];
              else      m_mem[t_addr[7:0]][8*b +: 8] = t_wdata[8*b +: 8];
            end
          end
        end else begin
          m_rdata = t_io ? m_sw : m_mem[t_addr[7:0]];
        end
      end
      chk("ack",   {31'd0, bus.cpu_ack},  {31'd0, ack_e});
      chk("busy",  {31'd0, bus.cpu_busy}, {31'd0, busy_e});
      chk("ce",    {31'd0, CE}, {31'd0, !win_e});
      chk("oe",    {31'd0, OE}, {31'd0, !(win_e && !t_we)});
      chk("we",    {31'd0, WE}, {31'd0, !(win_e && t_we)});
      chk("lb",    {31'd0, LB}, {31'd0, win_e ? (t_we ? ~t_be[0] : 1'b0) : 1'b1});
      chk("ub",    {31'd0, UB}, {31'd0, win_e ? (t_we ? ~t_be[1] : 1'b0) : 1'b1});
      chk("data_oe", {31'd0, Data_oe}, {31'd0, win_e && t_we});
      chk("addr",  {12'd0, A}, {12'd0, a_e});
      chk("rdata", {16'd0, bus.cpu_rdata}, {16'd0, m_rdata});
      chk("hex",   {16'd0, HEX}, {16'd0, m_hex});
      if (win_e && t_we) chk("data_out", {16'd0, Data_out}, {16'd0, t_wdata});
      if (bus.cpu_ack) begin ack_cnt++; last_ack_cyc = cyc; end
      if (!CE) ce_low++;
      if (!OE) oe_low++;
      if (!WE) we_low++;
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic we, input logic [19:0] addr,
                       input logic [15:0] wd, input logic [1:0] be);
    @(negedge Clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    bus.cpu_be    = be;
    req_cyc       = cyc;
    if (!(t_have && cyc >= t_k && cyc <= t_ack)) begin
      if (t_have) prev_addr = t_addr;
      t_have  = 1'b1;
      t_we    = we;
      t_io    = (addr == IO_A);
      t_addr  = addr;
      t_wdata = wd;
      t_be    = be;
      t_k     = cyc + 1;
      t_ack   = t_io ? t_k + 1 : t_k + WS + 1;
    end
    @(posedge Clk);
    #1 bus.cpu_req = 1'b0;
  endtask

  task automatic settle();
    repeat (WS + 4) @(negedge Clk);
  endtask

  int ack0, ce0, oe0, we0;

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]  = 16'h1000 + 16'(i);
      m_mem[i] = 16'h1000 + 16'(i);
    end
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
    bus.cpu_wdata = '0; bus.cpu_be = '0;
    Switches = 16'h5A5A;
    m_sw     = 16'h5A5A;

    #22;
    chk("rst_ce",    {31'd0, CE}, 32'd1);
    chk("rst_oe_we", {30'd0, OE, WE}, 32'd3);
    chk("rst_ub_lb", {30'd0, UB, LB}, 32'd3);
    chk("rst_addr",  {12'd0, A}, 32'd0);
    chk("rst_dout",  {15'd0, Data_oe, Data_out}, 32'd0);
    chk("rst_cpu",   {14'd0, bus.cpu_ack, bus.cpu_busy, bus.cpu_rdata}, 32'd0);
    chk("rst_hex",   {16'd0, HEX}, 32'd0);
`ifdef MEM_IO_BRIDGE_SEG_EN
    chk("rst_seg",   {4'd0, SEG}, 32'h0FFF_FFFF);
`endif
    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);

    // memory write
    ce0 = ce_low; we0 = we_low;
    issue(1'b1, 20'h00010, 16'hBEEF, 2'b11);
    settle();
    chk("wr_latency", last_ack_cyc - req_cyc, 32'd3);
    chk("wr_ce_cycles", ce_low - ce0, 32'd2);
    chk("wr_we_cycles", we_low - we0, 32'd2);

    // memory read back
    oe0 = oe_low;
    issue(1'b0, 20'h00010, 16'h0000, 2'b00);
    settle();
    chk("rd_latency", last_ack_cyc - req_cyc, 32'd3);
    chk("rd_oe_cycles", oe_low - oe0, 32'd2);
    chk("rd_beef", {16'd0, bus.cpu_rdata}, 32'h0000BEEF);

    // a write leaves rdata alone
    issue(1'b1, 20'h00011, 16'h1111, 2'b11);
    settle();
    chk("rd_hold", {16'd0, bus.cpu_rdata}, 32'h0000BEEF);

    // IO writes with byte enables
    ce0 = ce_low;
    issue(1'b1, IO_A, 16'hABCD, 2'b11);
    settle();
    issue(1'b1, IO_A, 16'h1234, 2'b01);
    settle();
    chk("io_wr_latency", last_ack_cyc - req_cyc, 32'd2);
    chk("hex_ab34", {16'd0, HEX}, 32'h0000AB34);
    chk("io_wr_no_ce", ce_low - ce0, 32'd0);

    // IO read of synchronised switches
    ce0 = ce_low; oe0 = oe_low; we0 = we_low;
    issue(1'b0, IO_A, 16'h0000, 2'b00);
    settle();
    chk("io_rd_sw", {16'd0, bus.cpu_rdata}, 32'h00005A5A);
    chk("io_rd_no_strobe", (ce_low - ce0) + (oe_low - oe0) + (we_low - we0), 32'd0);

    // byte-enable boundaries
    issue(1'b1, 20'h00020, 16'hFFFF, 2'b00);
    settle();
    issue(1'b0, 20'h00020, 16'h0000, 2'b00);
    settle();
    chk("be0_unchanged", {16'd0, bus.cpu_rdata}, 32'h00001020);
    issue(1'b1, 20'h00020, 16'hC3C3, 2'b10);
    settle();
    issue(1'b0, 20'h00020, 16'h0000, 2'b00);
    settle();
    chk("be_upper", {16'd0, bus.cpu_rdata}, 32'h0000C320);

    // requests while busy and during DONE are dropped
    ack0 = ack_cnt; ce0 = ce_low;
    issue(1'b1, 20'h00030, 16'h7777, 2'b11);
    for (int i = 0; i < WS + 2; i++) issue(1'b1, 20'h00031, 16'h0001, 2'b11);
    settle();
    chk("drop_one_ack", ack_cnt - ack0, 32'd1);
    chk("drop_one_access", ce_low - ce0, 32'd2);

    // reset in the middle of an access
    ack0 = ack_cnt;
    issue(1'b0, 20'h00010, 16'h0000, 2'b00);
    @(negedge Clk);
    #2 Reset = 1'b1;
    t_have = 1'b0; prev_addr = '0; m_hex = '0; m_rdata = '0;
    #1;
    chk("mid_rst_strobes", {29'd0, CE, OE, WE}, 32'd7);
    chk("mid_rst_busy_ack", {30'd0, bus.cpu_busy, bus.cpu_ack}, 32'd0);
    chk("mid_rst_hex", {16'd0, HEX}, 32'd0);
`ifdef MEM_IO_BRIDGE_SEG_EN
    chk("mid_rst_seg", {4'd0, SEG}, 32'h0FFF_FFFF);
`endif
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (5) @(negedge Clk);
    chk("mid_rst_no_ack", ack_cnt - ack0, 32'd0);

    // access after reset recovery
    issue(1'b0, 20'h00010, 16'h0000, 2'b00);
    settle();
    chk("post_rst_read", {16'd0, bus.cpu_rdata}, 32'h0000BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
